// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : irq_ctrl_pkg
// Brief   : Shared line count and priority helpers for the interrupt controller.
// Revision: 1.0
// ============================================================================
package irq_ctrl_pkg;

  localparam int C_N_IRQ   = 8;
  localparam int C_MAX_IRQ = 32;

  typedef logic [C_MAX_IRQ-1:0] irq_vec_t;

  // Isolates the lowest set bit; bit 0 is the highest priority.
  function automatic irq_vec_t lowest_bit(input irq_vec_t v);
    return v & (~v + irq_vec_t'(1));
  endfunction

  function automatic logic is_one_hot(input irq_vec_t v);
    return (v != '0) && ((v & (v - irq_vec_t'(1))) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module  : irq_sync
// Brief   : Per-line synchroniser, history flop and rising-edge detector.
// Revision: 1.0
// ============================================================================
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic irq_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // History resets low so a line held high through reset yields one request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign irq_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : irq_ctrl
// Brief   : Edge-latching interrupt controller with pending/in-service tracking.
// Revision: 1.0
// ============================================================================
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ       = C_N_IRQ,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic [N_IRQ-1:0] s_calli,
  input  logic [N_IRQ-1:0] s_reti,
  output logic [N_IRQ-1:0] min_bit_s,
  output logic [N_IRQ-1:0] min_bit_a,
  output logic [N_IRQ-1:0] pending,
  output logic             irq_err
);

  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_in_service;
  logic [N_IRQ-1:0] r_mask;
  logic             r_err;

  logic [N_IRQ-1:0] w_cand;
  logic             w_ack_ok;
  logic             w_reti_ok;
  logic [N_IRQ-1:0] w_ack;
  logic [N_IRQ-1:0] w_reti;
  logic             w_err_set;

  for (genvar k = 0; k < N_IRQ; k++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .irq_in  (irq_in[k]),
      .irq_edge(w_edge[k])
    );
  end

  assign w_cand    = r_pending & r_mask & ~r_in_service;
  assign w_ack_ok  = is_one_hot(irq_vec_t'(s_calli)) && ((s_calli & w_cand) != '0);
  assign w_reti_ok = is_one_hot(irq_vec_t'(s_reti)) && ((s_reti & r_in_service) != '0);
  assign w_ack     = w_ack_ok  ? s_calli : '0;
  assign w_reti    = w_reti_ok ? s_reti  : '0;
  assign w_err_set = ((s_calli != '0) && !w_ack_ok) || ((s_reti != '0) && !w_reti_ok);

  // Ack is applied after reti so it wins when both name the same line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending    <= '0;
      r_in_service <= '0;
      r_mask       <= '1;
      r_err        <= 1'b0;
    end else begin
      r_pending    <= (r_pending & ~w_ack) | w_edge;
      r_in_service <= (r_in_service & ~w_reti) | w_ack;
      if (mask_we) begin
        r_mask <= mask_in;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign min_bit_s = N_IRQ'(lowest_bit(irq_vec_t'(w_cand)));
  assign min_bit_a = N_IRQ'(lowest_bit(irq_vec_t'(r_in_service)));
  assign pending   = r_pending;
  assign irq_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_irq_ctrl
// Brief   : Vector table, hand sequences and randomised model check for irq_ctrl.
// Revision: 1.0
// ============================================================================
module tb_irq_ctrl;

  localparam int N = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_in = '1;
  logic [N-1:0] s_calli = '0;
  logic [N-1:0] s_reti = '0;
  logic [N-1:0] min_bit_s;
  logic [N-1:0] min_bit_a;
  logic [N-1:0] pending;
  logic         irq_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_ctrl #(
    .N_IRQ      (N),
    .SYNC_STAGES(S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .mask_we  (mask_we),
    .mask_in  (mask_in),
    .s_calli  (s_calli),
    .s_reti   (s_reti),
    .min_bit_s(min_bit_s),
    .min_bit_a(min_bit_a),
    .pending  (pending),
    .irq_err  (irq_err)
  );

  typedef struct {
    logic [N-1:0] irq;
    logic         mwe;
    logic [N-1:0] mask;
    logic [N-1:0] calli;
    logic [N-1:0] reti;
    logic [N-1:0] es;
    logic [N-1:0] ea;
    logic [N-1:0] ep;
    logic         ee;
  } vec_t;

  vec_t tbl[24];

  // Reference model: per-line bits plus a history of sampled line values.
  logic [N-1:0] m_pend, m_insvc, m_mask;
  logic         m_err;
  logic [N-1:0] m_q[$];

  function automatic logic [N-1:0] first_of(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) begin
        r = '0;
        r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_insvc = '0;
    m_mask = '1;
    m_err = 1'b0;
    m_q.delete();
    for (int i = 0; i <= S; i++) m_q.push_back('0);
  endtask

  task automatic model_step();
    logic [N-1:0] cand, edg, n_pend, n_insvc;
    logic         ack_ok, reti_ok;
    // Oldest entries are the samples taken S and S+1 edges ago.
    edg = m_q[1] & ~m_q[0];
    m_q.push_back(irq_in);
    void'(m_q.pop_front());
    cand = m_pend & m_mask & ~m_insvc;
    ack_ok = 1'b0;
    reti_ok = 1'b0;
    for (int k = 0; k < N; k++) begin
      if ($countones(s_calli) == 1 && s_calli[k] && cand[k]) ack_ok = 1'b1;
      if ($countones(s_reti) == 1 && s_reti[k] && m_insvc[k]) reti_ok = 1'b1;
    end
    n_pend = m_pend;
    n_insvc = m_insvc;
    for (int k = 0; k < N; k++) begin
      if (ack_ok && s_calli[k]) begin
        n_insvc[k] = 1'b1;
        n_pend[k] = edg[k];
      end else begin
        n_pend[k] = m_pend[k] | edg[k];
        if (reti_ok && s_reti[k]) n_insvc[k] = 1'b0;
      end
    end
    if ((s_calli != 0 && !ack_ok) || (s_reti != 0 && !reti_ok)) m_err = 1'b1;
    if (mask_we) m_mask = mask_in;
    m_pend = n_pend;
    m_insvc = n_insvc;
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " min_bit_s"}, min_bit_s, first_of(m_pend & m_mask & ~m_insvc));
    check({tag, " min_bit_a"}, min_bit_a, first_of(m_insvc));
    check({tag, " pending"}, pending, m_pend);
    check({tag, " irq_err"}, {7'd0, irq_err}, {7'd0, m_err});
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] es, input logic [N-1:0] ea,
                           input logic [N-1:0] ep, input logic ee);
    check({tag, " min_bit_s"}, min_bit_s, es);
    check({tag, " min_bit_a"}, min_bit_a, ea);
    check({tag, " pending"}, pending, ep);
    check({tag, " irq_err"}, {7'd0, irq_err}, {7'd0, ee});
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] irq, input logic mwe, input logic [N-1:0] mask,
                       input logic [N-1:0] calli, input logic [N-1:0] reti);
    irq_in = irq;
    mask_we = mwe;
    mask_in = mask;
    s_calli = calli;
    s_reti = reti;
  endtask

  function automatic logic [N-1:0] pick_bit(input logic [N-1:0] v);
    int idx[$];
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) if (v[k]) idx.push_back(k);
    if (idx.size() != 0) r[idx[$urandom_range(0, idx.size() - 1)]] = 1'b1;
    return r;
  endfunction

  task automatic rand_cycles(input int n, input bit legal);
    logic [N-1:0] cand;
    for (int i = 0; i < n; i++) begin
      cand = m_pend & m_mask & ~m_insvc;
      irq_in = irq_in ^ N'($urandom & $urandom & $urandom);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = N'($urandom) | N'($urandom);
      s_calli = '0;
      s_reti = '0;
      case ($urandom_range(0, 3))
        1, 2: s_calli = pick_bit(cand);
        3: if (!legal) s_calli = N'($urandom);
        default: ;
      endcase
      case ($urandom_range(0, 3))
        1: s_reti = pick_bit(m_insvc);
        2: if (!legal) s_reti = N'($urandom);
        default: ;
      endcase
      step();
      check_model($sformatf("rand%0d", i));
    end
  endtask

  initial begin
    //                irq    mwe   mask   calli  reti   es     ea     ep     ee
    tbl[0]  = '{8'h08, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{8'h00, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{8'h00, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h08, 8'h00, 8'h08, 1'b0};
    tbl[3]  = '{8'h00, 1'b0, 8'hFF, 8'h08, 8'h00, 8'h00, 8'h08, 8'h00, 1'b0};
    tbl[4]  = '{8'h22, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 1'b0};
    tbl[5]  = '{8'h22, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 1'b0};
    tbl[6]  = '{8'h22, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h08, 8'h22, 1'b0};
    tbl[7]  = '{8'h00, 1'b0, 8'hFF, 8'h02, 8'h00, 8'h20, 8'h02, 8'h20, 1'b0};
    tbl[8]  = '{8'h00, 1'b0, 8'hFF, 8'h00, 8'h02, 8'h20, 8'h08, 8'h20, 1'b0};
    tbl[9]  = '{8'h00, 1'b0, 8'hFF, 8'h20, 8'h00, 8'h00, 8'h08, 8'h00, 1'b0};
    tbl[10] = '{8'h00, 1'b0, 8'hFF, 8'h00, 8'h20, 8'h00, 8'h08, 8'h00, 1'b0};
    tbl[11] = '{8'h20, 1'b1, 8'hDF, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 1'b0};
    tbl[12] = '{8'h20, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 1'b0};
    tbl[13] = '{8'h20, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h08, 8'h20, 1'b0};
    tbl[14] = '{8'h00, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h20, 8'h08, 8'h20, 1'b0};
    tbl[15] = '{8'h00, 1'b0, 8'hFF, 8'h0C, 8'h00, 8'h20, 8'h08, 8'h20, 1'b1};
    tbl[16] = '{8'h00, 1'b0, 8'hFF, 8'h00, 8'h40, 8'h20, 8'h08, 8'h20, 1'b1};
    tbl[17] = '{8'h00, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h20, 8'h08, 8'h20, 1'b1};
    tbl[18] = '{8'h10, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h20, 8'h08, 8'h20, 1'b1};
    tbl[19] = '{8'h00, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h20, 8'h08, 8'h20, 1'b1};
    tbl[20] = '{8'h00, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h10, 8'h08, 8'h30, 1'b1};
    tbl[21] = '{8'h10, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h10, 8'h08, 8'h30, 1'b1};
    tbl[22] = '{8'h00, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h10, 8'h08, 8'h30, 1'b1};
    tbl[23] = '{8'h00, 1'b0, 8'hFF, 8'h10, 8'h00, 8'h20, 8'h08, 8'h30, 1'b1};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(8'h00, 1'b0, 8'hFF, 8'h00, 8'h00);
      step();
      check_all($sformatf("idle%0d", i), 8'h00, 8'h00, 8'h00, 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].irq, tbl[i].mwe, tbl[i].mask, tbl[i].calli, tbl[i].reti);
      step();
      check_all($sformatf("row%0d", i), tbl[i].es, tbl[i].ea, tbl[i].ep, tbl[i].ee);
    end

    // Asynchronous reset in the middle of a cycle with two lines in service.
    drive(8'h01, 1'b0, 8'hFF, 8'h00, 8'h00);
    #3;
    reset = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Line 0 already high at release: exactly one request.
    step();
    check_all("hi_at_release e1", 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    check_all("hi_at_release e2", 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    check_all("hi_at_release e3", 8'h01, 8'h00, 8'h01, 1'b0);
    drive(8'h01, 1'b0, 8'hFF, 8'h01, 8'h00);
    step();
    check_all("hi_at_release ack", 8'h00, 8'h01, 8'h00, 1'b0);
    drive(8'h01, 1'b0, 8'hFF, 8'h00, 8'h00);
    repeat (4) step();
    check_all("hi_at_release held", 8'h00, 8'h01, 8'h00, 1'b0);
    drive(8'h01, 1'b0, 8'hFF, 8'h00, 8'h01);
    step();
    check_all("hi_at_release reti", 8'h00, 8'h00, 8'h00, 1'b0);

    drive(8'h00, 1'b0, 8'hFF, 8'h00, 8'h00);
    rand_cycles(300, 1'b1);
    rand_cycles(300, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
